// File: rtl/onn_settle_controller_if.sv
// Handshake and phase-vector bundle between the oscillator array / host and the
// settle controller. Both phase vectors are indexed [0:59] (15 oscillators x 4 bits).
interface onn_settle_controller_if;
  logic        start;
  logic        period_tick;
  logic [0:59] phi_out;
  logic        osc_load;
  logic        osc_run;
  logic        phi_to_no;
  logic [0:59] phi_snap;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    output start, period_tick, phi_out,
    input  osc_load, osc_run, phi_to_no, phi_snap, busy, done, timeout
  );

  modport slave (
    input  start, period_tick, phi_out,
    output osc_load, osc_run, phi_to_no, phi_snap, busy, done, timeout
  );
endinterface

// File: rtl/onn_settle_controller.sv
// Sequences an oscillatory network: load pattern, run until the sampled phase
// vector repeats SETTLE_COUNT times in a row (or MAX_PERIODS elapse), then snapshot it.
module onn_settle_controller #(
  parameter int LOAD_CYCLES  = 2,
  parameter int SETTLE_COUNT = 4,
  parameter int MAX_PERIODS  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  onn_settle_controller_if.slave bus
);

  localparam int LW = $clog2(LOAD_CYCLES + 1);
  localparam int PW = $clog2(MAX_PERIODS + 1);
  localparam int SW = $clog2(SETTLE_COUNT + 1);

  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [LW-1:0] L_ONE     = LW'(1);
  localparam logic [PW-1:0] P_MAX     = PW'(MAX_PERIODS);
  localparam logic [PW-1:0] P_ONE     = PW'(1);
  localparam logic [SW-1:0] S_SETTLE  = SW'(SETTLE_COUNT);
  localparam logic [SW-1:0] S_ONE     = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [0:59]   prev_phi_q, prev_phi_d;
  logic [0:59]   phi_snap_q, phi_snap_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic          osc_load_q, osc_load_d;
  logic          osc_run_q, osc_run_d;
  logic          phi_to_no_q, phi_to_no_d;
  logic          busy_q, busy_d;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    period_cnt_d = period_cnt_q;
    stable_cnt_d = stable_cnt_q;
    prev_phi_d   = prev_phi_q;
    phi_snap_d   = phi_snap_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = S_LOAD;
          load_cnt_d   = '0;
          period_cnt_d = '0;
          stable_cnt_d = '0;
          timeout_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d    = S_RUN;
          load_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + L_ONE;
        end
      end
      S_RUN: begin
        if (bus.period_tick) begin
          period_cnt_d = period_cnt_q + P_ONE;
          prev_phi_d   = bus.phi_out;
          // The first tick of a run has nothing to compare against yet
          if (period_cnt_q == '0) begin
            stable_cnt_d = '0;
          end else if (bus.phi_out == prev_phi_q) begin
            stable_cnt_d = stable_cnt_q + S_ONE;
          end else begin
            stable_cnt_d = '0;
          end
          // Settling takes priority over hitting the period limit on the same tick
          if (stable_cnt_d == S_SETTLE) begin
            state_d    = S_DONE;
            phi_snap_d = bus.phi_out;
            timeout_d  = 1'b0;
          end else if (period_cnt_d == P_MAX) begin
            state_d    = S_DONE;
            phi_snap_d = bus.phi_out;
            timeout_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    osc_load_d  = (state_d == S_LOAD);
    osc_run_d   = (state_d == S_RUN);
    phi_to_no_d = (state_d == S_DONE);
    busy_d      = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d      = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State, counters and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      period_cnt_q <= '0;
      stable_cnt_q <= '0;
      prev_phi_q   <= '0;
      phi_snap_q   <= '0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      osc_load_q   <= 1'b0;
      osc_run_q    <= 1'b0;
      phi_to_no_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      period_cnt_q <= period_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      prev_phi_q   <= prev_phi_d;
      phi_snap_q   <= phi_snap_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      osc_load_q   <= osc_load_d;
      osc_run_q    <= osc_run_d;
      phi_to_no_q  <= phi_to_no_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.osc_load  = osc_load_q;
  assign bus.osc_run   = osc_run_q;
  assign bus.phi_to_no = phi_to_no_q;
  assign bus.phi_snap  = phi_snap_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule
